muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative signed multiply/divide engine for the multicycle CPU: one shared shift/add
//   datapath plus the FSM and counter that sequence it. Started by mult_start/div_start
//   from the control unit. Reports busy/done/divzero back to it. Results feed HI/LO.
//   The control unit waits on done; divzero steers it to the divide-by-zero exception.
// PARAMETERS
//   WIDTH  32  operand width; products are 2*WIDTH, quotient/remainder are WIDTH each
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk         in   1        clock, all state updates on rising edge
//   reset       in   1        synchronous, active-high
//   mult_start  in   1        request signed multiply op_a*op_b (sampled in IDLE only)
//   div_start   in   1        request signed divide op_a/op_b (sampled in IDLE only)
//   op_a        in   WIDTH    multiplicand / dividend, latched at start
//   op_b        in   WIDTH    multiplier / divisor, latched at start
//   busy        out  1        operation in progress
//   done        out  1        one-cycle pulse: result valid (or divzero)
//   divzero     out  1        one-cycle pulse coincident with done when divisor==0
//   hi_res      out  WIDTH    mult: product[2W-1:W]; div: remainder
//   lo_res      out  WIDTH    mult: product[W-1:0];  div: quotient
// BEHAVIOUR
//   Reset: state IDLE; busy, done, divzero, hi_res, lo_res, counter, internal regs = 0.
//   Reset mid-operation aborts it immediately: no done is produced, results are zeroed.
//   States: IDLE, MULT, DIV, FINISH, DZERO.
//   IDLE:
//     - mult_start=1 at edge t0: latch operands, counter=0, -> MULT, busy=1.
//     - div_start=1 (mult_start=0): if op_b==0 -> DZERO, busy=1;
//       else latch |op_a|, |op_b| and the sign flags, counter=0, -> DIV, busy=1.
//     - Both starts in the same cycle: multiply wins; the divide is dropped, not queued.
//   Starts while busy=1 are ignored (no queueing, no error).
//   MULT: radix-2 Booth, one step per cycle, WIDTH steps (edges t1..tWIDTH);
//     counter increments each step; after the step with counter==WIDTH-1 -> FINISH.
//   DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH steps,
//     then -> FINISH.
//   FINISH (edge tWIDTH+1):
//     - Load hi_res/lo_res, then done=1 for one cycle, busy=0, -> IDLE.
//     - Div sign fix: quotient negated iff the operand signs differ (truncate toward
//       zero); remainder takes the sign of the dividend.
//     - Most-negative / -1: lo_res = most-negative value, hi_res = 0; no flag.
//   DZERO (edge t1): done=1 and divzero=1 for one cycle, busy=0, hi_res/lo_res unchanged,
//     -> IDLE.
//   Latency: done high in the cycle after edge tWIDTH+1 (WIDTH+1 edges after start edge);
//     divzero case after 1 edge.
//   busy is high from t0 to the FINISH/DZERO edge.
//   A new start is accepted in the cycle where done=1 (state is already IDLE).
//   hi_res/lo_res hold their value until the next FINISH or reset.
//   Operands may change after t0 without effect.
//   All arithmetic is two's complement; no overflow flag for multiply (full 2W product).
// TESTING
//   1 mult 7 * 0xFFFFFFFD -> hi=0xFFFFFFFF lo=0xFFFFFFEB; done exactly 33 edges after start
//   2 mult 0x80000000 * 0x80000000 -> hi=0x40000000 lo=0x00000000; busy high 33 cycles
//   3 div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//   4 div 5 / 0 -> done=divzero=1 one edge after start; hi/lo retain prior result
//   5 mult_start pulsed while busy -> ignored, single done; mult_start+div_start same cycle -> mult result
//   6 reset at t0+10 of a divide -> busy=0, hi/lo=0, no done; next mult 3*4 -> lo=12 hi=0

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine for the multicycle CPU.
// One shared (WIDTH+1)-bit adder serves both the radix-2 Booth multiply
// and the restoring divide; a small FSM plus an iteration counter sequence it.
// Multiply: WIDTH Booth steps on {acc, q, q_m1}, product = {acc[W-1:0], q}.
// Divide: WIDTH restoring steps on magnitudes, sign fix applied in FINISH.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MULT   = 3'd1;
  localparam logic [2:0] ST_DIV    = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_DZERO  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Architectural and datapath state
  logic [2:0]       state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [WIDTH:0]   acc_reg,     acc_next;     // Booth partial product / divide remainder
  logic [WIDTH-1:0] q_reg,       q_next;       // multiplier shift reg / dividend->quotient
  logic             qm1_reg,     qm1_next;     // Booth q[-1] bit
  logic [WIDTH-1:0] m_reg,       m_next;       // multiplicand / divisor magnitude
  logic             is_div_reg,  is_div_next;
  logic             neg_q_reg,   neg_q_next;   // operand signs differ
  logic             neg_r_reg,   neg_r_next;   // dividend negative
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             divzero_reg, divzero_next;
  logic [WIDTH-1:0] hi_reg,      hi_next;
  logic [WIDTH-1:0] lo_reg,      lo_next;

  // Shared adder and operand conditioning
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic [1:0]       booth_bits;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign divzero = divzero_reg;
  assign hi_res  = hi_reg;
  assign lo_res  = lo_reg;

  // Operand magnitudes; the most-negative value maps to 2**(WIDTH-1) as unsigned
  always_comb begin
    abs_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    abs_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  end

  // Shared adder: Booth add/subtract of the multiplicand, or divide trial subtract
  always_comb begin
    booth_bits = {q_reg[0], qm1_reg};
    // divisor magnitude is unsigned; multiplicand is sign-extended to avoid overflow
    m_ext      = is_div_reg ? {1'b0, m_reg} : {m_reg[WIDTH-1], m_reg};
    div_shift  = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    add_a      = is_div_reg ? div_shift : acc_reg;
    add_sub    = is_div_reg || (booth_bits == 2'b10);
    add_b      = add_sub ? ~m_ext : m_ext;
    add_sum    = add_a + add_b + {{WIDTH{1'b0}}, add_sub};
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    quot_fixed = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
    rem_fixed  = neg_r_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
  end

  // Next-state logic for the sequencer FSM and the shared datapath
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    qm1_next     = qm1_reg;
    m_next       = m_reg;
    is_div_next  = is_div_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    divzero_next = 1'b0;
    hi_next      = hi_reg;
    lo_next      = lo_reg;

    case (state_reg)
      ST_IDLE: begin
        // multiply wins over a simultaneous divide; the divide is dropped
        if (mult_start) begin
          m_next      = op_a;
          q_next      = op_b;
          acc_next    = '0;
          qm1_next    = 1'b0;
          cnt_next    = '0;
          is_div_next = 1'b0;
          neg_q_next  = 1'b0;
          neg_r_next  = 1'b0;
          busy_next   = 1'b1;
          state_next  = ST_MULT;
        end else if (div_start) begin
          busy_next = 1'b1;
          if (op_b == '0) begin
            state_next = ST_DZERO;
          end else begin
            m_next      = abs_b;
            q_next      = abs_a;
            acc_next    = '0;
            qm1_next    = 1'b0;
            cnt_next    = '0;
            is_div_next = 1'b1;
            neg_q_next  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_r_next  = op_a[WIDTH-1];
            state_next  = ST_DIV;
          end
        end
      end

      ST_MULT: begin
        // add/sub selected by the Booth pair, then arithmetic shift right of {acc,q,q_m1}
        if (booth_bits == 2'b01 || booth_bits == 2'b10) begin
          acc_next = {add_sum[WIDTH], add_sum[WIDTH:1]};
          q_next   = {add_sum[0], q_reg[WIDTH-1:1]};
        end else begin
          acc_next = {acc_reg[WIDTH], acc_reg[WIDTH:1]};
          q_next   = {acc_reg[0], q_reg[WIDTH-1:1]};
        end
        qm1_next = q_reg[0];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next = ST_FINISH;
        end
      end

      ST_DIV: begin
        // shift remainder left, keep the trial difference when it is non-negative
        if (add_sum[WIDTH]) begin
          acc_next = div_shift;
        end else begin
          acc_next = add_sum;
        end
        q_next   = {q_reg[WIDTH-2:0], ~add_sum[WIDTH]};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next = ST_FINISH;
        end
      end

      ST_FINISH: begin
        if (is_div_reg) begin
          hi_next = rem_fixed;
          lo_next = quot_fixed;
        end else begin
          hi_next = acc_reg[WIDTH-1:0];
          lo_next = q_reg;
        end
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      ST_DZERO: begin
        // results are left untouched so HI/LO keep the previous operation's value
        done_next    = 1'b1;
        divzero_next = 1'b1;
        busy_next    = 1'b0;
        state_next   = ST_IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that also aborts any running operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      m_reg       <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      qm1_reg     <= qm1_next;
      m_reg       <= m_next;
      is_div_reg  <= is_div_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      divzero_reg <= divzero_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_start(mult_start),
    .div_start (div_start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .divzero   (divzero),
    .hi_res    (hi_res),
    .lo_res    (lo_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, then wait (bounded) for done; sampling is 1ns after each edge
  task automatic run_op(input logic is_mul, input logic is_dv,
                        input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cycles, output logic dz);
    @(negedge clk);
    mult_start = is_mul;
    div_start  = is_dv;
    op_a       = a;
    op_b       = b;
    @(posedge clk);
    #1;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    op_a        = 32'hDEAD_BEEF;   // operands must not matter after the start edge
    op_b        = 32'h0BAD_F00D;
    busy_cycles = busy ? 1 : 0;
    edges       = 0;
    dz          = 1'b0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        dz = divzero;
        break;
      end
      if (busy) busy_cycles++;
    end
    $display("txn mul=%0b div=%0b a=%h b=%h -> hi=%h lo=%h edges=%0d dz=%0b",
             is_mul, is_dv, a, b, hi_res, lo_res, edges, dz);
  endtask

  int   edges;
  int   bcyc;
  logic dz;
  int   dones;

  initial begin
    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(divzero), 64'd0);
    chk("rst_hi",   64'(hi_res), 64'd0);
    chk("rst_lo",   64'(lo_res), 64'd0);
    reset = 1'b0;

    // 1: 7 * -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, edges, bcyc, dz);
    chk("m1_edges", 64'(edges), 64'd33);
    chk("m1_hi", 64'(hi_res), 64'hFFFF_FFFF);
    chk("m1_lo", 64'(lo_res), 64'hFFFF_FFEB);
    chk("m1_dz", 64'(dz), 64'd0);
    @(posedge clk); #1;
    chk("m1_done_pulse", 64'(done), 64'd0);

    // 2: most-negative squared = 2**62
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, edges, bcyc, dz);
    chk("m2_busy_cycles", 64'(bcyc), 64'd33);
    chk("m2_busy_at_done", 64'(busy), 64'd0);
    chk("m2_hi", 64'(hi_res), 64'h4000_0000);
    chk("m2_lo", 64'(lo_res), 64'h0000_0000);

    // -1 * -1 = 1
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcyc, dz);
    chk("m3_hi", 64'(hi_res), 64'h0);
    chk("m3_lo", 64'(lo_res), 64'h1);

    // 3: divides with sign fix-up
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, edges, bcyc, dz);
    chk("d1_edges", 64'(edges), 64'd33);
    chk("d1_lo", 64'(lo_res), 64'hFFFF_FFFD);
    chk("d1_hi", 64'(hi_res), 64'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, edges, bcyc, dz);
    chk("d2_lo", 64'(lo_res), 64'd14);
    chk("d2_hi", 64'(hi_res), 64'd2);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, edges, bcyc, dz);   // -100 / 7
    chk("d3_lo", 64'(lo_res), 64'hFFFF_FFF2);
    chk("d3_hi", 64'(hi_res), 64'hFFFF_FFFE);
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, edges, bcyc, dz);   // 100 / -7
    chk("d4_lo", 64'(lo_res), 64'hFFFF_FFF2);
    chk("d4_hi", 64'(hi_res), 64'd2);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcyc, dz);
    chk("d5_lo", 64'(lo_res), 64'h8000_0000);
    chk("d5_hi", 64'(hi_res), 64'h0);
    chk("d5_dz", 64'(dz), 64'd0);

    // 4: divide by zero, results retained
    run_op(1'b0, 1'b1, 32'd5, 32'd0, edges, bcyc, dz);
    chk("dz_edges", 64'(edges), 64'd1);
    chk("dz_flag", 64'(dz), 64'd1);
    chk("dz_lo", 64'(lo_res), 64'h8000_0000);
    chk("dz_hi", 64'(hi_res), 64'h0);
    @(posedge clk); #1;
    chk("dz_pulse", 64'(divzero), 64'd0);

    // 5a: start pulses while busy are ignored
    @(negedge clk);
    mult_start = 1'b1;
    op_a = 32'd6;
    op_b = 32'd7;
    @(posedge clk); #1;
    mult_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (i == 5) begin
        mult_start = 1'b1;
        div_start  = 1'b1;
        op_a = 32'd100;
        op_b = 32'd100;
      end
      if (i == 6) begin
        mult_start = 1'b0;
        div_start  = 1'b0;
      end
    end
    $display("txn mul busy-restart 6*7 -> hi=%h lo=%h dones=%0d", hi_res, lo_res, dones);
    chk("busy_ign_dones", 64'(dones), 64'd1);
    chk("busy_ign_lo", 64'(lo_res), 64'd42);
    chk("busy_ign_hi", 64'(hi_res), 64'd0);

    // 5b: both starts together, multiply wins (-5*4 = -20)
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd4, edges, bcyc, dz);
    chk("both_edges", 64'(edges), 64'd33);
    chk("both_hi", 64'(hi_res), 64'hFFFF_FFFF);
    chk("both_lo", 64'(lo_res), 64'hFFFF_FFEC);
    chk("both_dz", 64'(dz), 64'd0);

    // 6: reset during a divide aborts it
    @(negedge clk);
    div_start = 1'b1;
    op_a = 32'd100;
    op_b = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi_res), 64'd0);
    chk("abort_lo", 64'(lo_res), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    $display("txn div aborted by reset -> hi=%h lo=%h dones=%0d", hi_res, lo_res, dones);
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, edges, bcyc, dz);
    chk("post_lo", 64'(lo_res), 64'd12);
    chk("post_hi", 64'(hi_res), 64'd0);
    chk("post_edges", 64'(edges), 64'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
